sisc_mc_core: RTL and testbench

Parametrised multicycle successor to the single-instruction SISC datapath. It integrates fetch, decode, execute and writeback under one FSM, with a program counter and an instruction-fetch handshake, so it no longer needs an externally sequenced instruction word. Data width, register-file depth and address width are parameters. Conditional/relative branching, a HALT state and a debug register read port are added.

---
 rtl/sisc_mc_core.sv | 149 ++++++++++++++
 tb/tb_sisc_mc_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mc_core.sv
// Multicycle SISC core: FETCH/DECODE/EXECUTE/WRITEBACK/HALTED sequencer with a
// program counter, instruction-fetch handshake, flag-conditional branching and a debug read port.
module sisc_mc_core #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 16,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [31:0]       instr_data,
  output logic [3:0]        stat,
  output logic              retire,
  output logic              halted,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALTED} state_t;

  localparam int MSB = DATA_W - 1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  // Sixteen slots so any 4-bit index is addressable; slots at or above RF_DEPTH are never written.
  logic [DATA_W-1:0] rf [16];

  logic [3:0] op, mm, rd, rs, rt;
  assign op = ir[31:28];
  assign mm = ir[27:24];
  assign rd = ir[23:20];
  assign rs = ir[19:16];
  assign rt = ir[15:12];

  logic signed [15:0] imm_s;
  logic [DATA_W-1:0]  imm_x;
  assign imm_s = ir[15:0];
  assign imm_x = DATA_W'(imm_s);

  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
    return (idx != 4'd0 && 32'(idx) < RF_DEPTH) ? rf[idx] : '0;
  endfunction

  assign dbg_data   = rd_reg(dbg_addr);
  assign instr_addr = pc;

  logic              is_alu, taken, alu_c, alu_v;
  logic [DATA_W-1:0] opnd, alu_r;
  logic [DATA_W:0]   sum;

  assign is_alu = (op == 4'd1) || (op == 4'd2);
  assign taken  = (mm == 4'd0) || ((stat & mm) != 4'd0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    opnd  = (op == 4'd1) ? b_q : imm_x;
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (mm)
      4'd1: begin
        sum   = {1'b0, a_q} + {1'b0, ~opnd} + (DATA_W+1)'(1);
        alu_r = sum[MSB:0];
        alu_c = sum[DATA_W];
        alu_v = (a_q[MSB] != opnd[MSB]) && (alu_r[MSB] != a_q[MSB]);
      end
      4'd2: alu_r = a_q & opnd;
      4'd3: alu_r = a_q | opnd;
      4'd4: alu_r = a_q ^ opnd;
      4'd5: alu_r = ~a_q;
      4'd6: begin
        alu_r = {a_q[MSB-1:0], 1'b0};
        alu_c = a_q[MSB];
      end
      4'd7: begin
        alu_r = {1'b0, a_q[MSB:1]};
        alu_c = a_q[0];
      end
      default: begin
        sum   = {1'b0, a_q} + {1'b0, opnd};
        alu_r = sum[MSB:0];
        alu_c = sum[DATA_W];
        alu_v = (a_q[MSB] == opnd[MSB]) && (alu_r[MSB] != a_q[MSB]);
      end
    endcase
  end

  // NOTE: all state below is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      stat      <= '0;
      instr_req <= 1'b1;
      retire    <= 1'b0;
      halted    <= 1'b0;
      // NOTE: the register file is architecturally zero after reset, so it is reset like any flop.
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: if (instr_req && instr_valid) begin
          ir        <= instr_data;
          pc        <= pc + ADDR_W'(1);
          instr_req <= 1'b0;
          state     <= DECODE;
        end
        DECODE: begin
          a_q   <= rd_reg(rs);
          b_q   <= rd_reg(rt);
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (is_alu) begin
            res_q <= alu_r;
            stat  <= {alu_c, alu_r[MSB], alu_v, (alu_r == '0)};
          end
          // pc already points past this instruction, so BRR is relative to the next address.
          if (op == 4'd4 && taken) pc <= ir[ADDR_W-1:0];
          if (op == 4'd5 && taken) pc <= pc + ir[ADDR_W-1:0];
          retire <= 1'b1;
          state  <= WRITEBACK;
        end
        WRITEBACK: begin
          if (is_alu && rd != 4'd0 && 32'(rd) < RF_DEPTH) rf[rd] <= res_q;
          if (op == 4'd15) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else begin
            instr_req <= 1'b1;
            state     <= FETCH;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_mc_core.sv
// Randomized bench for sisc_mc_core: an instruction-level model predicts pc, flags and
// registers, and a negedge compare process checks every DUT output each cycle.
module tb_sisc_mc_core;
  localparam int DATA_W = 32, RF_DEPTH = 16, ADDR_W = 16;

  logic              clk = 1'b0, rst_f = 1'b0;
  logic              instr_req, instr_valid = 1'b0;
  logic [ADDR_W-1:0] instr_addr;
  logic [31:0]       instr_data = '0;
  logic [3:0]        stat, dbg_addr = '0;
  logic              retire, halted;
  logic [DATA_W-1:0] dbg_data;

  always #5 clk = ~clk;

  sisc_mc_core #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_f(rst_f), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data), .stat(stat), .retire(retire),
    .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  int n_checks = 0, n_pass = 0;

  // Architectural model state
  logic [31:0] mrf [16];
  logic [15:0] m_pc;
  logic [3:0]  m_stat;
  logic        m_halt, e_req, e_retire;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    m_pc = '0; m_stat = '0; m_halt = 1'b0; e_req = 1'b1; e_retire = 1'b0;
  endtask

  always @(negedge clk) if (chk_en) begin
    check("instr_req", 64'(instr_req), 64'(e_req));
    check("instr_addr", 64'(instr_addr), 64'(m_pc));
    check("retire", 64'(retire), 64'(e_retire));
    check("halted", 64'(halted), 64'(m_halt));
    check("stat", 64'(stat), 64'(m_stat));
    check("dbg_data", 64'(dbg_data), 64'(mrf[dbg_addr]));
  end

  task automatic step();
    @(posedge clk);
    #1;
    dbg_addr = 4'($urandom);
  endtask

  task automatic peek(input string name, input logic [3:0] idx, input logic [63:0] exp);
    dbg_addr = idx;
    #1;
    check(name, 64'(dbg_data), exp);
  endtask

  // Instruction semantics computed with wide integer arithmetic; m_pc is already incremented.
  task automatic model_exec(input logic [31:0] w, output logic wr, output logic [31:0] val,
                            output logic [15:0] npc, output logic [3:0] nst, output logic hlt);
    logic [3:0]      op, mm;
    logic [31:0]     a, b;
    longint unsigned u;
    longint          sr;
    logic            c, v;
    op  = w[31:28];
    mm  = w[27:24];
    a   = mrf[w[19:16]];
    b   = (op == 4'd1) ? mrf[w[15:12]] : {{16{w[15]}}, w[15:0]};
    wr  = 1'b0; val = '0; npc = m_pc; nst = m_stat; hlt = (op == 4'd15);
    c   = 1'b0; v = 1'b0;
    if (op == 4'd1 || op == 4'd2) begin
      case (mm)
        4'd1: begin
          val = a - b;
          c   = (a >= b);
          sr  = longint'(signed'(a)) - longint'(signed'(b));
          v   = (sr != longint'(signed'(val)));
        end
        4'd2: val = a & b;
        4'd3: val = a | b;
        4'd4: val = a ^ b;
        4'd5: val = ~a;
        4'd6: begin val = a << 1; c = a[31]; end
        4'd7: begin val = a >> 1; c = a[0]; end
        default: begin
          u   = longint'(a) + longint'(b);
          val = u[31:0];
          c   = u[32];
          sr  = longint'(signed'(a)) + longint'(signed'(b));
          v   = (sr != longint'(signed'(val)));
        end
      endcase
      nst = {c, val[31], v, (val == 32'd0)};
      wr  = (w[23:20] != 4'd0);
    end
    if ((op == 4'd4 || op == 4'd5) && (mm == 4'd0 || (m_stat & mm) != 4'd0))
      npc = (op == 4'd4) ? w[15:0] : m_pc + w[15:0];
  endtask

  // Issue one instruction after wt wait-state cycles; returns in the cycle after WRITEBACK.
  task automatic run(input logic [31:0] w, input int wt);
    logic        wr, hlt;
    logic [31:0] val;
    logic [15:0] npc;
    logic [3:0]  nst;
    repeat (wt) begin
      instr_valid = 1'b0;
      instr_data  = $urandom;
      step();
    end
    instr_valid = 1'b1;
    instr_data  = w;
    step();
    instr_valid = 1'($urandom);
    instr_data  = $urandom;
    m_pc  = m_pc + 16'd1;
    e_req = 1'b0;
    model_exec(w, wr, val, npc, nst, hlt);
    step();
    step();
    m_stat   = nst;
    m_pc     = npc;
    e_retire = 1'b1;
    step();
    if (wr) mrf[w[23:20]] = val;
    e_retire    = 1'b0;
    m_halt      = hlt;
    e_req       = !hlt;
    instr_valid = 1'b0;
  endtask

  logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd4, 4'd5, 4'd3, 4'd9};
  logic [31:0] rw;

  initial begin
    model_reset();
    chk_en      = 1'b1;
    instr_valid = 1'b1;
    repeat (3) step();
    rst_f       = 1'b1;
    instr_valid = 1'b0;
    check("reset_req", 64'(instr_req), 64'd1);
    check("reset_addr", 64'(instr_addr), 64'd0);
    for (int i = 0; i < 16; i++) begin
      peek("reset_reg", 4'(i), 64'd0);
      step();
    end

    run(32'h20100005, 0);
    peek("addi_r1", 4'd1, 64'd5);
    check("addi_stat", 64'(stat), 64'b0000);
    check("addi_addr", 64'(instr_addr), 64'd1);
    run(32'h2010FFFF, 0);
    peek("neg_r1", 4'd1, 64'hFFFF_FFFF);
    check("neg_stat", 64'(stat), 64'b0100);
    run(32'h20210001, 1);
    peek("carry_r2", 4'd2, 64'd0);
    check("carry_stat", 64'(stat), 64'b1001);
    run(32'h41000040, 0);
    check("bra_taken", 64'(instr_addr), 64'h0040);
    run(32'h20300003, 0);
    run(32'h41000040, 0);
    check("bra_not_taken", 64'(instr_addr), 64'h0042);
    run(32'h40000000, 0);
    run(32'h5000FFFF, 0);
    check("brr_wrap", 64'(instr_addr), 64'h0000);
    run(32'h4000FFFF, 0);
    check("bra_top", 64'(instr_addr), 64'hFFFF);
    run(32'h00000000, 0);
    check("pc_inc_wrap", 64'(instr_addr), 64'h0000);
    run(32'h20000007, 3);
    peek("r0_zero", 4'd0, 64'd0);
    run(32'h21310002, 1);
    peek("sub_r3", 4'd3, 64'hFFFF_FFFD);
    check("sub_stat", 64'(stat), 64'b1100);

    for (int n = 0; n < 400; n++) begin
      rw = $urandom;
      rw[31:28] = ops[$urandom_range(0, 9)];
      run(rw, $urandom_range(0, 3));
    end

    run(32'hF0000000, 0);
    repeat (25) begin
      instr_valid = 1'($urandom);
      step();
    end
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_req", 64'(instr_req), 64'd0);

    rst_f = 1'b0;
    model_reset();
    step();
    step();
    rst_f       = 1'b1;
    instr_valid = 1'b0;
    run(32'h20500009, 0);
    peek("post_halt_r5", 4'd5, 64'd9);
    instr_valid = 1'b1;
    instr_data  = 32'h20600004;
    step();
    rst_f = 1'b0;
    model_reset();
    step();
    step();
    rst_f       = 1'b1;
    instr_valid = 1'b0;
    step();
    peek("midreset_r6", 4'd6, 64'd0);
    peek("midreset_r5", 4'd5, 64'd0);
    check("midreset_addr", 64'(instr_addr), 64'd0);
    step();
    run(32'h20700001, 1);
    peek("restart_r7", 4'd7, 64'd1);
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
